// File: rtl/savestate_seq_pkg.sv
// Shared types and header helpers for the savestate bus sequencer.
// The header word carries the magic, a format version and the register count.
package savestate_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_DEF   = 4'd1,
    ST_S_HDR = 4'd2,
    ST_S_RD  = 4'd3,
    ST_S_WR  = 4'd4,
    ST_L_HDR = 4'd5,
    ST_L_RD  = 4'd6,
    ST_L_WR  = 4'd7,
    ST_FIN   = 4'd8
  } ss_state_e;

  localparam logic [15:0] SS_MAGIC_DEFAULT = 16'h5353;
  localparam logic [15:0] SS_HDR_VERSION   = 16'h0001;

  localparam int HDR_MAGIC_MSB = 63;
  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_COUNT_MSB = 9;
  localparam int HDR_COUNT_LSB = 0;

  function automatic logic [63:0] ss_header(input logic [15:0] magic, input logic [9:0] count);
    return {magic, SS_HDR_VERSION, 22'd0, count};
  endfunction

  function automatic logic ss_header_ok(input logic [15:0] magic_f, input logic [9:0] count_f,
                                        input logic [15:0] magic,   input logic [9:0] count);
    return (magic_f == magic) && (count_f == count);
  endfunction

endpackage

// File: rtl/savestate_mem_handshake.sv
// Single-outstanding memory request holder: keeps req/addr/we/wdata stable until ack,
// and reports the ack together with the read data of that cycle.
module savestate_mem_handshake
  import savestate_seq_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic          o_ack,
  output logic [63:0]   o_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [63:0]   o_mem_wdata,
  input  logic [63:0]   i_mem_rdata,
  input  logic          i_mem_ack
);

  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [63:0]   r_wdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 64'd0;
    end else if (i_start) begin
      r_req   <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (r_req && i_mem_ack) begin
      r_req <= 1'b0;
    end else begin
      r_req <= r_req;
    end
  end

  assign o_ack       = r_req & i_mem_ack;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/savestate_bus_sequencer.sv
// Savestate bus master: walks every register index to save it to memory, restore it
// from memory, or broadcast a load-defaults strobe to all slaves.
module savestate_bus_sequencer
  import savestate_seq_pkg::*;
#(
  parameter int          NUM_REGS       = 64,
  parameter int          MEM_AW         = 22,
  parameter int          BUS_RD_LATENCY = 1,
  parameter logic [15:0] SS_MAGIC       = SS_MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_save,
  input  logic              i_cmd_load,
  input  logic              i_cmd_defaults,
  input  logic [MEM_AW-1:0] i_mem_base,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [9:0]        o_ss_bus_adr,
  output logic [63:0]       o_ss_bus_din,
  output logic              o_ss_bus_wren,
  output logic              o_ss_bus_rst,
  input  logic [63:0]       i_ss_bus_dout,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  input  logic [63:0]       i_mem_rdata,
  input  logic              i_mem_ack
);

  localparam logic [9:0] LP_COUNT  = 10'(NUM_REGS);
  localparam logic [9:0] LP_LAST   = 10'(NUM_REGS - 1);
  localparam logic [1:0] LP_RD_LAT = 2'(BUS_RD_LATENCY);

  ss_state_e         r_state;
  logic [9:0]        r_idx;
  logic [1:0]        r_rd_cnt;
  logic [MEM_AW-1:0] r_base;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [9:0]        r_adr;
  logic [63:0]       r_din;
  logic              r_wren;
  logic              r_bus_rst;
  logic              r_hs_start;
  logic              r_hs_we;
  logic [MEM_AW-1:0] r_hs_addr;
  logic [63:0]       r_hs_wdata;

  logic              w_ack;
  logic [63:0]       w_rdata;
  logic              w_hdr_ok;
  logic [MEM_AW-1:0] w_slot_cur;
  logic [MEM_AW-1:0] w_slot_next;

  // Register i lives one word past the header; the sum wraps at the address width.
  assign w_slot_cur  = r_base + MEM_AW'(r_idx) + MEM_AW'(1);
  assign w_slot_next = w_slot_cur + MEM_AW'(1);
  assign w_hdr_ok    = ss_header_ok(w_rdata[HDR_MAGIC_MSB:HDR_MAGIC_LSB],
                                    w_rdata[HDR_COUNT_MSB:HDR_COUNT_LSB], SS_MAGIC, LP_COUNT);

  savestate_mem_handshake #(.AW(MEM_AW)) u_mem_hs (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (r_hs_start),
    .i_we        (r_hs_we),
    .i_addr      (r_hs_addr),
    .i_wdata     (r_hs_wdata),
    .o_ack       (w_ack),
    .o_rdata     (w_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 10'd0;
      r_rd_cnt   <= 2'd0;
      r_base     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_adr      <= 10'd0;
      r_din      <= 64'd0;
      r_wren     <= 1'b0;
      r_bus_rst  <= 1'b0;
      r_hs_start <= 1'b0;
      r_hs_we    <= 1'b0;
      r_hs_addr  <= '0;
      r_hs_wdata <= 64'd0;
    end else begin
      r_hs_start <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wren     <= 1'b0;
      r_bus_rst  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx <= 10'd0;
          if (i_cmd_defaults) begin
            r_state   <= ST_DEF;
            r_busy    <= 1'b1;
            r_bus_rst <= 1'b1;
          end else if (i_cmd_load) begin
            r_state    <= ST_L_HDR;
            r_busy     <= 1'b1;
            r_base     <= i_mem_base;
            r_hs_start <= 1'b1;
            r_hs_we    <= 1'b0;
            r_hs_addr  <= i_mem_base;
          end else if (i_cmd_save) begin
            r_state    <= ST_S_HDR;
            r_busy     <= 1'b1;
            r_base     <= i_mem_base;
            r_hs_start <= 1'b1;
            r_hs_we    <= 1'b1;
            r_hs_addr  <= i_mem_base;
            r_hs_wdata <= ss_header(SS_MAGIC, LP_COUNT);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DEF: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_FIN;
        end
        ST_S_HDR: begin
          if (w_ack) begin
            r_state  <= ST_S_RD;
            r_adr    <= 10'd0;
            r_rd_cnt <= 2'd0;
          end
        end
        // Data is taken only after the slave read latency has fully elapsed.
        ST_S_RD: begin
          if (r_rd_cnt == LP_RD_LAT) begin
            r_state    <= ST_S_WR;
            r_hs_start <= 1'b1;
            r_hs_we    <= 1'b1;
            r_hs_addr  <= w_slot_cur;
            r_hs_wdata <= i_ss_bus_dout;
          end else begin
            r_rd_cnt <= r_rd_cnt + 2'd1;
          end
        end
        ST_S_WR: begin
          if (w_ack) begin
            if (r_idx == LP_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_FIN;
            end else begin
              r_idx    <= r_idx + 10'd1;
              r_adr    <= r_idx + 10'd1;
              r_rd_cnt <= 2'd0;
              r_state  <= ST_S_RD;
            end
          end
        end
        ST_L_HDR: begin
          if (w_ack) begin
            if (w_hdr_ok) begin
              r_state    <= ST_L_RD;
              r_hs_start <= 1'b1;
              r_hs_we    <= 1'b0;
              r_hs_addr  <= w_slot_cur;
            end else begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_L_RD: begin
          if (w_ack) begin
            r_din   <= w_rdata;
            r_adr   <= r_idx;
            r_wren  <= 1'b1;
            r_state <= ST_L_WR;
          end
        end
        // The next read is issued only after the write strobe, keeping req and strobes apart.
        ST_L_WR: begin
          if (r_idx == LP_LAST) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FIN;
          end else begin
            r_idx      <= r_idx + 10'd1;
            r_hs_start <= 1'b1;
            r_hs_we    <= 1'b0;
            r_hs_addr  <= w_slot_next;
            r_state    <= ST_L_RD;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_ss_bus_adr  = r_adr;
  assign o_ss_bus_din  = r_din;
  assign o_ss_bus_wren = r_wren;
  assign o_ss_bus_rst  = r_bus_rst;

endmodule

// File: tb/tb_savestate_bus_sequencer.sv
// Directed + randomized bench for savestate_bus_sequencer with a behavioural memory,
// a behavioural slave bus and an image-level reference of what save/load must produce.
module tb_savestate_bus_sequencer;

  localparam int NR = 64;
  localparam int AW = 22;
  localparam logic [63:0] HDR_GOOD = {16'h5353, 16'h0001, 22'd0, 10'd64};
  localparam logic [63:0] HDR_BAD  = {16'h0000, 16'h0001, 22'd0, 10'd64};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_save = 1'b0, cmd_load = 1'b0, cmd_defaults = 1'b0;
  logic [AW-1:0] mem_base = '0;
  logic          o_busy, o_done, o_error, o_ss_bus_wren, o_ss_bus_rst;
  logic [9:0]    o_ss_bus_adr;
  logic [63:0]   o_ss_bus_din, o_mem_wdata;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [63:0]   ss_bus_dout = 64'd0;
  logic [63:0]   mem_rdata = 64'd0;
  logic          mem_ack = 1'b0;

  savestate_bus_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_save(cmd_save), .i_cmd_load(cmd_load),
    .i_cmd_defaults(cmd_defaults), .i_mem_base(mem_base), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_ss_bus_adr(o_ss_bus_adr), .o_ss_bus_din(o_ss_bus_din),
    .o_ss_bus_wren(o_ss_bus_wren), .o_ss_bus_rst(o_ss_bus_rst), .i_ss_bus_dout(ss_bus_dout),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  logic [63:0]   mem [logic [AW-1:0]];
  logic [63:0]   slave_val [NR];
  logic [63:0]   exp_slot [NR];
  int            ack_lat = 1;
  int            n_wr, n_rd, done_cnt, err_cnt, rst_cnt, req_cyc, inv_bad;
  logic [AW-1:0] wq_addr [$];
  logic [9:0]    bq_adr [$];
  logic [63:0]   bq_din [$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [63:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + 1 + i) % (1 << AW));
  endfunction

  // Memory: acks a held request after ack_lat clocks.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (o_mem_req && !reset) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          if (o_mem_we) begin
            mem[o_mem_addr] = o_mem_wdata;
            wq_addr.push_back(o_mem_addr);
            n_wr++;
          end else begin
            mem_rdata = mem_rd(o_mem_addr);
            n_rd++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Slave bus: OR of slaves is modelled as a lookup, 0 for undecoded indices.
  initial forever begin
    @(posedge clk); #1;
    ss_bus_dout = (o_ss_bus_adr < 10'(NR)) ? slave_val[o_ss_bus_adr[5:0]] : 64'd0;
  end

  initial forever begin
    @(negedge clk);
    if (o_done) done_cnt++;
    if (o_error) err_cnt++;
    if (o_ss_bus_rst) rst_cnt++;
    if (o_mem_req) req_cyc++;
    if (o_ss_bus_wren) begin
      bq_adr.push_back(o_ss_bus_adr);
      bq_din.push_back(o_ss_bus_din);
    end
    if (o_ss_bus_wren && o_ss_bus_rst) inv_bad++;
    if (o_mem_req && (o_ss_bus_wren || o_ss_bus_rst)) inv_bad++;
    if (o_done && o_error) inv_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_wr = 0; n_rd = 0; done_cnt = 0; err_cnt = 0; rst_cnt = 0; req_cyc = 0;
    wq_addr.delete(); bq_adr.delete(); bq_din.delete();
  endtask

  task automatic pulse(input logic d, input logic l, input logic s);
    @(negedge clk);
    cmd_defaults = d; cmd_load = l; cmd_save = s;
    @(negedge clk);
    cmd_defaults = 1'b0; cmd_load = 1'b0; cmd_save = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!(o_done || o_error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_finished"}, 64'(o_done || o_error), 64'd1);
  endtask

  task automatic randomize_slaves();
    for (int i = 0; i < NR; i++) slave_val[i] = (i < 53) ? {$urandom, $urandom} : 64'd0;
  endtask

  task automatic run_save(input logic [AW-1:0] base, input int lat, input bit poke_load,
                          input string tag);
    ack_lat = lat;
    clear_logs();
    mem_base = base;
    pulse(1'b0, 1'b0, 1'b1);
    if (poke_load) begin
      repeat (20) @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0);
    end
    wait_end(20000, tag);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_n_rd"}, 64'(n_rd), 64'd0);
    chk({tag, "_n_wr"}, 64'(n_wr), 64'(NR + 1));
    chk({tag, "_busy_end"}, 64'(o_busy), 64'd0);
    for (int i = 0; i <= NR; i++) begin
      chk($sformatf("%s_wr_order_%0d", tag, i),
          64'((i < wq_addr.size()) ? wq_addr[i] : {AW{1'b1}}),
          64'((i == 0) ? base : slot_addr(base, i - 1)));
    end
    chk({tag, "_header"}, mem_rd(base), HDR_GOOD);
    for (int i = 0; i < NR; i++) begin
      exp_slot[i] = slave_val[i];
      chk($sformatf("%s_slot_%0d", tag, i), mem_rd(slot_addr(base, i)), exp_slot[i]);
    end
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int lat, input string tag);
    ack_lat = lat;
    clear_logs();
    mem_base = base;
    pulse(1'b0, 1'b1, 1'b0);
    wait_end(20000, tag);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_wren_cnt"}, 64'(bq_adr.size()), 64'(NR));
    chk({tag, "_n_rd"}, 64'(n_rd), 64'(NR + 1));
    chk({tag, "_n_wr"}, 64'(n_wr), 64'd0);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_adr_%0d", tag, i),
          64'((i < bq_adr.size()) ? bq_adr[i] : 10'h3FF), 64'(i));
      chk($sformatf("%s_din_%0d", tag, i),
          (i < bq_din.size()) ? bq_din[i] : 64'hDEAD_DEAD_DEAD_DEAD, exp_slot[i]);
    end
  endtask

  initial begin
    logic [AW-1:0] base;
    logic [63:0]   w;
    int            k;
    bit            found;
    inv_bad = 0;
    clear_logs();
    for (int i = 0; i < NR; i++) slave_val[i] = 64'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_error", 64'(o_error), 64'd0);
    chk("rst_wren", 64'(o_ss_bus_wren), 64'd0);
    chk("rst_bus_rst", 64'(o_ss_bus_rst), 64'd0);
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_adr", 64'(o_ss_bus_adr), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Save with a single populated slave and slow memory.
    base = 22'h001000;
    slave_val[7] = 64'hE064000000000000;
    run_save(base, 3, 1'b0, "save7");

    // Load back with one slot patched.
    mem[slot_addr(base, 16)] = 64'h1234;
    exp_slot[16] = 64'h1234;
    run_load(base, 2, "load16");

    // Load against a corrupted header.
    mem[base] = HDR_BAD;
    clear_logs();
    mem_base = base;
    pulse(1'b0, 1'b1, 1'b0);
    wait_end(2000, "badhdr");
    chk("badhdr_error_pulse", 64'(o_error), 64'd1);
    chk("badhdr_busy_at_err", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("badhdr_busy_next", 64'(o_busy), 64'd0);
    chk("badhdr_error_once", 64'(o_error), 64'd0);
    repeat (3) @(negedge clk);
    chk("badhdr_err_cnt", 64'(err_cnt), 64'd1);
    chk("badhdr_done_cnt", 64'(done_cnt), 64'd0);
    chk("badhdr_wren_cnt", 64'(bq_adr.size()), 64'd0);
    chk("badhdr_n_rd", 64'(n_rd), 64'd1);

    // Defaults wins over save in the same clock.
    clear_logs();
    pulse(1'b1, 1'b0, 1'b1);
    wait_end(100, "defaults");
    repeat (3) @(negedge clk);
    chk("defaults_rst_cnt", 64'(o_ss_bus_rst ? 99 : rst_cnt), 64'd1);
    chk("defaults_req_cyc", 64'(req_cyc), 64'd0);
    chk("defaults_done_cnt", 64'(done_cnt), 64'd1);
    chk("defaults_wren_cnt", 64'(bq_adr.size()), 64'd0);

    // Reset while a slot write is pending in memory.
    ack_lat = 6;
    clear_logs();
    mem_base = 22'h000200;
    pulse(1'b0, 1'b0, 1'b1);
    k = 0;
    found = 1'b0;
    while (!found && k < 2000) begin
      @(negedge clk);
      k++;
      found = o_mem_req && o_mem_we && (o_mem_addr != 22'h000200);
    end
    chk("midrst_found_swr", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_low", 64'(o_mem_req), 64'd0);
    chk("midrst_busy_low", 64'(o_busy), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_no_error", 64'(err_cnt), 64'd0);
    run_save(22'h000200, 2, 1'b0, "after_rst");

    // Wrapping slot addresses with random data; a load pulse while busy must be ignored.
    randomize_slaves();
    base = 22'h3FFFF6;
    run_save(base, $urandom_range(1, 4), 1'b1, "wrap");
    chk("wrap_slot9_at_0", mem_rd(22'h000000), slave_val[9]);

    // Randomized save/patch/load round trips.
    for (int r = 0; r < 2; r++) begin
      randomize_slaves();
      base = AW'($urandom_range(0, (1 << AW) - 1));
      run_save(base, $urandom_range(1, 4), 1'b0, $sformatf("rsave%0d", r));
      k = $urandom_range(0, NR - 1);
      w = {$urandom, $urandom};
      mem[slot_addr(base, k)] = w;
      exp_slot[k] = w;
      run_load(base, $urandom_range(1, 4), $sformatf("rload%0d", r));
    end

    chk("strobe_invariants", 64'(inv_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
